// File: rtl/song_pkg.sv
// Shared constants and types for the song scheduler.
// Latency: n/a (package). Backpressure: n/a.
// Contents: per-song tick divisors and lengths in beats, the FSM state type and the song index type.
package song_pkg;

   localparam int NUM_SONGS = 8;
   localparam int DIV_W     = 24;

   typedef logic [2:0] song_idx_t;

   typedef enum logic [1:0] {IDLE, START, PLAY} state_t;

   // Core clock cycles per beat for each song.
   localparam logic [DIV_W-1:0] DIV [NUM_SONGS] = '{
      24'd8388608, 24'd5242880, 24'd3495253, 24'd2097152,
      24'd4194304, 24'd4194304, 24'd4194304, 24'd4194304
   };

   // Song length in beats. Songs 5 and 6 are reserved placeholders.
   localparam int LEN [NUM_SONGS] = '{112, 112, 112, 112, 10, 1, 1, 256};

endpackage

// File: rtl/song_scheduler_tempo_tick.sv
// Beat tick generator: a counter that wraps every div cycles while enabled.
// Latency: tick is decoded from the count register, so it is high in the last cycle of each beat.
// Backpressure: none. clear wins over enable, and the count sits at 0 while enable is low.
// Ports: clk, rst (async, active high); clear loads div and zeroes the count;
// enable lets the count run; div is the cycles per beat; tick marks the last cycle of a beat.
module tempo_tick
   import song_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] divReg;
   logic [DIV_W-1:0] count;

   assign tick = enable && (count == divReg - 24'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         divReg <= 24'd1;
      end else if (clear) begin
         count  <= '0;
         divReg <= div;
      end else if (!enable || tick) begin
         count  <= '0;
      end else begin
         count  <= count + 24'd1;
      end
   end

endmodule

// File: rtl/song_scheduler.sv
// Song sequencer and arbiter. It queues play requests, picks the song with the lowest index and steps its beats.
// Latency: a request at cycle n shows in pending at n+1 and gives start_pulse at n+2. All outputs are registered.
// Backpressure: none. Requests stay in pending until their song starts, or until stop clears them.
// Ports: clk, rst (async, active high); req is the per-song play request; stop aborts the song and
// flushes the queue; song_sel and beat_num give the active song and its beat;
// playing, start_pulse, done_pulse and abort_pulse report status; pending holds the queued requests.
module song_scheduler
   import song_pkg::*;
#(
   parameter int FAST_DIV = 0,
   parameter int BEAT_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        req,
   input  logic              stop,
   output logic [2:0]        song_sel,
   output logic              playing,
   output logic [BEAT_W-1:0] beat_num,
   output logic              start_pulse,
   output logic              done_pulse,
   output logic              abort_pulse,
   output logic [7:0]        pending
);

   function automatic song_idx_t lowestSet(input logic [7:0] v);
      lowestSet = '0;
      for (int i = NUM_SONGS - 1; i >= 0; i--) begin
         if (v[i]) lowestSet = song_idx_t'(i);
      end
   endfunction

   state_t            state;
   song_idx_t         selNext;
   logic              preempt;
   logic              goStart;
   logic              tick;
   logic [7:0]        clearMask;
   logic [DIV_W-1:0]  divSel;
   logic [BEAT_W-1:0] lastBeat;

   assign selNext   = lowestSet(pending);
   // An equal index also preempts, which restarts the current song.
   assign preempt   = (pending != 8'd0) && (selNext <= song_sel);
   assign clearMask = (state == START) ? (8'd1 << song_sel) : 8'd0;
   assign lastBeat  = BEAT_W'(LEN[song_sel] - 1);
   assign divSel    = (FAST_DIV != 0) ? DIV_W'(FAST_DIV) : DIV[selNext];

   // done_pulse high while in PLAY marks the tail cycle of a finished song. That cycle
   // cannot be preempted and returns to IDLE, so playing drops one cycle after done_pulse.
   assign goStart = !stop && (((state == IDLE) && (pending != 8'd0)) ||
                              ((state == PLAY) && !done_pulse && preempt));

   tempo_tick uTick (
      .clk    (clk),
      .rst    (rst),
      .clear  (goStart),
      .enable ((state == START) || (state == PLAY)),
      .div    (divSel),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         song_sel    <= '0;
         playing     <= 1'b0;
         beat_num    <= '0;
         start_pulse <= 1'b0;
         done_pulse  <= 1'b0;
         abort_pulse <= 1'b0;
         pending     <= '0;
      end else begin
         start_pulse <= 1'b0;
         done_pulse  <= 1'b0;
         abort_pulse <= 1'b0;
         // A new request for a bit wins over the clear of that bit.
         pending     <= (pending & ~clearMask) | req;

         if (stop) begin
            pending     <= '0;
            state       <= IDLE;
            playing     <= 1'b0;
            abort_pulse <= (state != IDLE) && !done_pulse;
         end else if (goStart) begin
            state       <= START;
            song_sel    <= selNext;
            beat_num    <= '0;
            playing     <= 1'b1;
            start_pulse <= 1'b1;
            abort_pulse <= (state == PLAY);
         end else begin
            case (state)
               START: begin
                  state <= PLAY;
                  if (tick) begin
                     if (beat_num == lastBeat) done_pulse <= 1'b1;
                     else                      beat_num   <= beat_num + 1'b1;
                  end
               end
               PLAY: begin
                  if (done_pulse) begin
                     state   <= IDLE;
                     playing <= 1'b0;
                  end else if (tick) begin
                     if (beat_num == lastBeat) done_pulse <= 1'b1;
                     else                      beat_num   <= beat_num + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_scheduler.sv
module tb_song_scheduler;

   localparam int D = 4;
   localparam int LEN_T [8] = '{112, 112, 112, 112, 10, 1, 1, 256};

   logic        clk;
   logic        rst;
   logic [7:0]  req;
   logic        stop;
   logic [2:0]  song_sel;
   logic        playing;
   logic [11:0] beat_num;
   logic        start_pulse;
   logic        done_pulse;
   logic        abort_pulse;
   logic [7:0]  pending;

   song_scheduler #(.FAST_DIV(D), .BEAT_W(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .stop        (stop),
      .song_sel    (song_sel),
      .playing     (playing),
      .beat_num    (beat_num),
      .start_pulse (start_pulse),
      .done_pulse  (done_pulse),
      .abort_pulse (abort_pulse),
      .pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: phase 0 idle, 1 start, 2 play. Beat and completion come from elapsed time.
   int         mPhase = 0;
   int         mSong  = 0;
   int         mT0    = 0;
   int         mBeat  = 0;
   logic [7:0] mPend  = '0;
   bit         mStartP = 0;
   bit         mDoneP  = 0;
   bit         mAbortP = 0;

   typedef struct {
      logic [7:0]  r;
      logic        s;
      logic [7:0]  pend;
      logic        st;
      logic        ab;
      logic        dn;
      logic        pl;
      logic [2:0]  sel;
      logic [11:0] beat;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] dutVec();
      return {5'd0, pending, song_sel, playing, start_pulse, done_pulse, abort_pulse, beat_num};
   endfunction

   function automatic logic [31:0] modelVec();
      return {5'd0, mPend, 3'(mSong), (mPhase != 0), mStartP, mDoneP, mAbortP, 12'(mBeat)};
   endfunction

   task automatic launch(input int s);
      mPhase  = 1;
      mSong   = s;
      mT0     = cyc;
      mBeat   = 0;
      mStartP = 1;
   endtask

   task automatic modelStep(input logic [7:0] r, input logic s);
      logic [7:0] np;
      int lo;
      int el;
      bit wasDone;
      wasDone = mDoneP;
      lo      = lowest(mPend);
      mStartP = 0;
      mDoneP  = 0;
      mAbortP = 0;
      if (s) begin
         mAbortP = (mPhase != 0) && !wasDone;
         mPhase  = 0;
         mPend   = '0;
      end else begin
         np = mPend | r;
         if (mPhase == 1 && !r[mSong]) np[mSong] = 1'b0;
         if (mPhase == 0) begin
            if (lo >= 0) launch(lo);
         end else if (wasDone) begin
            mPhase = 0;
         end else if (mPhase == 2 && lo >= 0 && lo <= mSong) begin
            mAbortP = 1;
            launch(lo);
         end else begin
            mPhase = 2;
            el = cyc - mT0;
            if (el == LEN_T[mSong] * D) mDoneP = 1;
            else                         mBeat  = el / D;
         end
         mPend = np;
      end
   endtask

   task automatic step(input logic [7:0] r, input logic s);
      req  = r;
      stop = s;
      @(posedge clk);
      #1;
      cyc++;
      modelStep(r, s);
      req  = '0;
      stop = 1'b0;
      chk("model", dutVec(), modelVec());
   endtask

   task automatic waitStart(input string name, input int limit);
      int n;
      n = 0;
      while (!start_pulse && n < limit) begin
         step(8'h00, 1'b0);
         n++;
      end
      chk(name, 32'(start_pulse), 32'd1);
   endtask

   initial begin
      int n;
      int aborts;
      int dones;

      tbl[0]  = '{8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'd0};
      tbl[1]  = '{8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 12'd0};
      tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'd0};
      tbl[3]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'd0};
      tbl[4]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'd0};
      tbl[5]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'd1};
      tbl[6]  = '{8'h02, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'd1};
      tbl[7]  = '{8'h00, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 12'd0};
      tbl[8]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 12'd0};
      tbl[9]  = '{8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 12'd0};
      tbl[10] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'd0};

      rst  = 1'b1;
      req  = '0;
      stop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", dutVec(), 32'd0);
      rst = 1'b0;

      // Request, start, preempt by song 1, then stop with every request raised.
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].r, tbl[i].s);
         chk($sformatf("table%0d", i),
             {5'd0, pending, start_pulse, abort_pulse, done_pulse, playing, song_sel, beat_num},
             {5'd0, tbl[i].pend, tbl[i].st, tbl[i].ab, tbl[i].dn, tbl[i].pl, tbl[i].sel, tbl[i].beat});
      end

      // Song 4 runs to completion: 10 beats of D cycles each.
      step(8'h10, 1'b0);
      step(8'h00, 1'b0);
      chk("s4 start", {28'd0, start_pulse, song_sel}, {28'd0, 1'b1, 3'd4});
      for (int i = 1; i <= 40; i++) begin
         step(8'h00, 1'b0);
         chk("s4 beat", 32'(beat_num), (i < 40) ? i / D : 9);
         chk("s4 done", 32'(done_pulse), (i == 40) ? 1 : 0);
      end
      step(8'h00, 1'b0);
      chk("s4 idle", {19'd0, playing, beat_num}, {19'd0, 1'b0, 12'd9});

      // A lower-priority request waits for song 1 to finish.
      step(8'h02, 1'b0);
      waitStart("s1 start", 4);
      chk("s1 sel", 32'(song_sel), 32'd1);
      repeat (5) step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      aborts = 0;
      for (int i = 0; i < 10; i++) begin
         step(8'h00, 1'b0);
         if (abort_pulse) aborts++;
      end
      chk("s1 no abort", aborts, 0);
      chk("s3 held", 32'(pending), 32'h08);
      n = 0;
      while (!done_pulse && n < 600) begin
         step(8'h00, 1'b0);
         n++;
      end
      chk("s1 done", 32'(done_pulse), 32'd1);
      step(8'h00, 1'b0);
      chk("s3 not yet", 32'(start_pulse), 32'd0);
      step(8'h00, 1'b0);
      chk("s3 start", {28'd0, start_pulse, song_sel}, {28'd0, 1'b1, 3'd3});
      step(8'h00, 1'b1);
      chk("s3 stop", {23'd0, abort_pulse, pending}, {23'd0, 1'b1, 8'h00});
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      chk("s3 stopped", {30'd0, playing, abort_pulse}, 32'd0);

      // Song 0 restarts on its own request, then again on a request in its START cycle.
      step(8'h01, 1'b0);
      waitStart("s0 start", 4);
      repeat (10) step(8'h00, 1'b0);
      chk("s0 beat", 32'(beat_num), 32'd2);
      step(8'h01, 1'b0);
      chk("s0 pend", 32'(pending), 32'h01);
      step(8'h00, 1'b0);
      chk("s0 restart", {15'd0, abort_pulse, start_pulse, song_sel, beat_num},
          {15'd0, 1'b1, 1'b1, 3'd0, 12'd0});
      step(8'h01, 1'b0);
      chk("coll pend", {23'd0, start_pulse, pending}, {23'd0, 1'b0, 8'h01});
      step(8'h00, 1'b0);
      chk("coll restart", {27'd0, abort_pulse, start_pulse, song_sel}, {27'd0, 1'b1, 1'b1, 3'd0});
      step(8'h00, 1'b0);
      chk("coll clear", 32'(pending), 32'h00);
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);

      // A preempting request that lands on song 4's final beat tick.
      step(8'h10, 1'b0);
      waitStart("fb start", 4);
      for (int i = 1; i <= 38; i++) step(8'h00, 1'b0);
      step(8'h08, 1'b0);
      chk("fb pend", 32'(pending), 32'h08);
      dones  = 0;
      aborts = 0;
      for (int i = 0; i < 2; i++) begin
         step(8'h00, 1'b0);
         if (done_pulse)  dones++;
         if (abort_pulse) aborts++;
      end
      chk("fb no done", dones, 0);
      chk("fb abort", aborts, 1);
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);

      // Random requests and stops, checked against the model on every cycle.
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] r;
         logic s;
         r = ($urandom_range(0, 29) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         s = ($urandom_range(0, 149) == 0);
         step(r, s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
